// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the RV64IM divide group (DIV/DIVU/REM/REMU and *W forms).
// Special cases (divide by zero, signed overflow) finish in one cycle; normal ops take W+1 cycles.
module div_unit #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic            is_signed,
  input  logic            is_word,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] div_out,
  output logic [XLEN-1:0] rem_out
);

  localparam int unsigned HALF  = XLEN / 2;
  localparam int unsigned CNT_W = $clog2(XLEN + 1);
  localparam logic [HALF-1:0] MIN_H = {1'b1, {(HALF-1){1'b0}}};
  localparam logic [XLEN-1:0] MIN_X = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0] cnt_q, cnt_nxt;
  logic [XLEN-1:0]  rem_q, rem_nxt;
  logic [XLEN-1:0]  quo_q, quo_nxt;
  logic [XLEN-1:0]  dvs_q, dvs_nxt;
  logic             sign_q, sign_q_nxt;
  logic             sign_r, sign_r_nxt;
  logic             word_q, word_nxt;
  logic             done_nxt;
  logic [XLEN-1:0]  div_nxt, rem_out_nxt;

  logic [HALF-1:0]  a_lo, b_lo;
  logic             a_neg, b_neg;
  logic [XLEN-1:0]  a_mag, b_mag, a_ext;
  logic             div_zero, ovf, accept, special;
  logic [XLEN-1:0]  spec_q, spec_r;
  logic [XLEN:0]    shifted, trial;
  logic             keep;
  logic [XLEN-1:0]  q_signed, r_signed, q_fix, r_fix;

  function automatic logic [XLEN-1:0] sext_half(input logic [HALF-1:0] x);
    return {{HALF{x[HALF-1]}}, x};
  endfunction

  assign busy = (state != IDLE);

  // Operand conditioning: select width, detect special cases, take magnitudes
  always_comb begin
    a_lo  = a[HALF-1:0];
    b_lo  = b[HALF-1:0];
    a_neg = is_signed & (is_word ? a[HALF-1] : a[XLEN-1]);
    b_neg = is_signed & (is_word ? b[HALF-1] : b[XLEN-1]);
    if (is_word) begin
      a_mag    = {{HALF{1'b0}}, (a_neg ? (HALF'(0) - a_lo) : a_lo)};
      b_mag    = {{HALF{1'b0}}, (b_neg ? (HALF'(0) - b_lo) : b_lo)};
      div_zero = (b_lo == '0);
      ovf      = is_signed & (a_lo == MIN_H) & (b_lo == '1);
      a_ext    = sext_half(a_lo);
    end else begin
      a_mag    = a_neg ? (XLEN'(0) - a) : a;
      b_mag    = b_neg ? (XLEN'(0) - b) : b;
      div_zero = (b == '0);
      ovf      = is_signed & (a == MIN_X) & (b == '1);
      a_ext    = a;
    end
    special = div_zero | ovf;
    spec_q  = div_zero ? '1 : a_ext;
    spec_r  = div_zero ? a_ext : '0;
    accept  = start & ~flush & (state == IDLE);
  end

  // One restoring step plus final sign correction
  always_comb begin
    shifted  = {rem_q, quo_q[XLEN-1]};
    trial    = shifted - {1'b0, dvs_q};
    keep     = ~trial[XLEN];
    q_signed = sign_q ? (XLEN'(0) - quo_q) : quo_q;
    r_signed = sign_r ? (XLEN'(0) - rem_q) : rem_q;
    q_fix    = word_q ? sext_half(q_signed[HALF-1:0]) : q_signed;
    r_fix    = word_q ? sext_half(r_signed[HALF-1:0]) : r_signed;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept && !special) state_nxt = CALC;
      CALC: begin
        if (flush)                     state_nxt = IDLE;
        else if (cnt_q == CNT_W'(1))   state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt     = cnt_q;
    rem_nxt     = rem_q;
    quo_nxt     = quo_q;
    dvs_nxt     = dvs_q;
    sign_q_nxt  = sign_q;
    sign_r_nxt  = sign_r;
    word_nxt    = word_q;
    done_nxt    = 1'b0;
    div_nxt     = div_out;
    rem_out_nxt = rem_out;
    case (state)
      IDLE: begin
        if (accept && special) begin
          div_nxt     = spec_q;
          rem_out_nxt = spec_r;
          done_nxt    = 1'b1;
        end else if (accept) begin
          // word dividends sit in the upper half so only HALF shifts are needed
          rem_nxt    = '0;
          quo_nxt    = is_word ? {a_mag[HALF-1:0], {HALF{1'b0}}} : a_mag;
          dvs_nxt    = b_mag;
          cnt_nxt    = is_word ? CNT_W'(HALF) : CNT_W'(XLEN);
          sign_q_nxt = a_neg ^ b_neg;
          sign_r_nxt = a_neg;
          word_nxt   = is_word;
        end
      end
      CALC: begin
        if (!flush) begin
          rem_nxt = keep ? trial[XLEN-1:0] : shifted[XLEN-1:0];
          quo_nxt = {quo_q[XLEN-2:0], keep};
          cnt_nxt = cnt_q - CNT_W'(1);
        end
      end
      FIX: begin
        if (!flush) begin
          div_nxt     = q_fix;
          rem_out_nxt = r_fix;
          done_nxt    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      word_q  <= 1'b0;
      done    <= 1'b0;
      div_out <= '0;
      rem_out <= '0;
    end else begin
      cnt_q   <= cnt_nxt;
      rem_q   <= rem_nxt;
      quo_q   <= quo_nxt;
      dvs_q   <= dvs_nxt;
      sign_q  <= sign_q_nxt;
      sign_r  <= sign_r_nxt;
      word_q  <= word_nxt;
      done    <= done_nxt;
      div_out <= div_nxt;
      rem_out <= rem_out_nxt;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: latency, signed/unsigned/word results, special cases and flush.
// Latency is counted as rising edges after the start edge until done is seen.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        reset, start, is_signed, is_word, flush;
  logic [63:0] a, b;
  logic        busy, done;
  logic [63:0] div_out, rem_out;

  int n_cmp = 0;
  int n_err = 0;

  div_unit dut (
    .clk(clk), .reset(reset), .start(start), .is_signed(is_signed), .is_word(is_word),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done),
    .div_out(div_out), .rem_out(rem_out)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic s, input logic w, input logic [63:0] av, input logic [63:0] bv,
                       output int lat);
    @(negedge clk);
    start = 1'b1; is_signed = s; is_word = w; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    if (done) lat = 0;
    else begin
      for (int i = 1; i <= 100; i++) begin
        @(posedge clk); #1;
        if (done) begin lat = i; break; end
      end
    end
  endtask

  task automatic test_reset();
    int lat;
    reset = 1'b1; start = 1'b1; is_signed = 1'b0; is_word = 1'b0; flush = 1'b0;
    a = 64'd100; b = 64'd7;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (div_out !== 64'd0) begin n_err++; $display("FAIL reset_div: got %h want 0", div_out); end
    n_cmp++; if (rem_out !== 64'd0) begin n_err++; $display("FAIL reset_rem: got %h want 0", rem_out); end
    @(negedge clk); reset = 1'b0; start = 1'b0;
    do_op(1'b0, 1'b0, 64'd100, 64'd7, lat);
    n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL udiv_lat: got %0d want 65", lat); end
    n_cmp++; if (div_out !== 64'd14) begin n_err++; $display("FAIL udiv_q: got %h want %h", div_out, 64'd14); end
    n_cmp++; if (rem_out !== 64'd2) begin n_err++; $display("FAIL udiv_r: got %h want %h", rem_out, 64'd2); end
    @(posedge clk); #1;
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL done_pulse_width: got %b want 0", done); end
  endtask

  task automatic test_signed();
    int lat;
    do_op(1'b1, 1'b0, -64'sd7, 64'd2, lat);
    n_cmp++; if (div_out !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL sdiv1_q: got %h want fffffffffffffffd", div_out); end
    n_cmp++; if (rem_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL sdiv1_r: got %h want ffffffffffffffff", rem_out); end
    do_op(1'b1, 1'b0, 64'd7, -64'sd2, lat);
    n_cmp++; if (div_out !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_err++; $display("FAIL sdiv2_q: got %h want fffffffffffffffd", div_out); end
    n_cmp++; if (rem_out !== 64'd1) begin n_err++; $display("FAIL sdiv2_r: got %h want 1", rem_out); end
    // -2^63 / 3 = -0x2AAAAAAAAAAAAAAA rem -2
    do_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'd3, lat);
    n_cmp++; if (div_out !== 64'hD555_5555_5555_5556) begin n_err++; $display("FAIL sdiv3_q: got %h want d555555555555556", div_out); end
    n_cmp++; if (rem_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL sdiv3_r: got %h want fffffffffffffffe", rem_out); end
    do_op(1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1_0000_0000, lat);
    n_cmp++; if (div_out !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL udiv_big_q: got %h want ffffffff", div_out); end
    n_cmp++; if (rem_out !== 64'h0000_0000_FFFF_FFFF) begin n_err++; $display("FAIL udiv_big_r: got %h want ffffffff", rem_out); end
  endtask

  task automatic test_special();
    int lat;
    do_op(1'b1, 1'b0, 64'h1234, 64'd0, lat);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL sdivz_lat: got %0d want 0", lat); end
    n_cmp++; if (div_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL sdivz_q: got %h want ffffffffffffffff", div_out); end
    n_cmp++; if (rem_out !== 64'h1234) begin n_err++; $display("FAIL sdivz_r: got %h want 1234", rem_out); end
    do_op(1'b0, 1'b0, 64'h1234, 64'd0, lat);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL udivz_lat: got %0d want 0", lat); end
    n_cmp++; if (div_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL udivz_q: got %h want ffffffffffffffff", div_out); end
    n_cmp++; if (rem_out !== 64'h1234) begin n_err++; $display("FAIL udivz_r: got %h want 1234", rem_out); end
    do_op(1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'd0, lat);
    n_cmp++; if (div_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL divwz_q: got %h want ffffffffffffffff", div_out); end
    n_cmp++; if (rem_out !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL divwz_r: got %h want ffffffff80000000", rem_out); end
    do_op(1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, lat);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL ovf_lat: got %0d want 0", lat); end
    n_cmp++; if (div_out !== 64'h8000_0000_0000_0000) begin n_err++; $display("FAIL ovf_q: got %h want 8000000000000000", div_out); end
    n_cmp++; if (rem_out !== 64'd0) begin n_err++; $display("FAIL ovf_r: got %h want 0", rem_out); end
    do_op(1'b1, 1'b1, 64'h8000_0000, 64'hFFFF_FFFF, lat);
    n_cmp++; if (lat !== 0) begin n_err++; $display("FAIL ovfw_lat: got %0d want 0", lat); end
    n_cmp++; if (div_out !== 64'hFFFF_FFFF_8000_0000) begin n_err++; $display("FAIL ovfw_q: got %h want ffffffff80000000", div_out); end
    n_cmp++; if (rem_out !== 64'd0) begin n_err++; $display("FAIL ovfw_r: got %h want 0", rem_out); end
  endtask

  task automatic test_word();
    int lat;
    do_op(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL divuw_lat: got %0d want 33", lat); end
    n_cmp++; if (div_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL divuw_q: got %h want fffffffffffffffe", div_out); end
    n_cmp++; if (rem_out !== 64'd0) begin n_err++; $display("FAIL divuw_r: got %h want 0", rem_out); end
    do_op(1'b1, 1'b1, -64'sd9, 64'd4, lat);
    n_cmp++; if (lat !== 33) begin n_err++; $display("FAIL remw_lat: got %0d want 33", lat); end
    n_cmp++; if (div_out !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_err++; $display("FAIL remw_q: got %h want fffffffffffffffe", div_out); end
    n_cmp++; if (rem_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_err++; $display("FAIL remw_r: got %h want ffffffffffffffff", rem_out); end
  endtask

  task automatic test_flush();
    int lat;
    int pulses;
    do_op(1'b0, 1'b0, 64'd100, 64'd7, lat);
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; is_word = 1'b0; a = 64'h1000; b = 64'h10;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 1; i <= 9; i++) begin
      @(negedge clk);
      start = (i == 3);
      a = 64'd5; b = 64'd1;
      @(posedge clk); #1;
    end
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL flush_busy_pre: got %b want 1", busy); end
    @(negedge clk); start = 1'b0; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL flush_busy_post: got %b want 0", busy); end
    pulses = 0;
    for (int i = 0; i < 80; i++) begin
      @(posedge clk); #1;
      if (done) pulses++;
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL flush_done: got %0d pulses want 0", pulses); end
    n_cmp++; if (div_out !== 64'd14) begin n_err++; $display("FAIL flush_hold_q: got %h want e", div_out); end
    n_cmp++; if (rem_out !== 64'd2) begin n_err++; $display("FAIL flush_hold_r: got %h want 2", rem_out); end
    do_op(1'b0, 1'b0, 64'h1000, 64'h10, lat);
    n_cmp++; if (lat !== 65) begin n_err++; $display("FAIL post_flush_lat: got %0d want 65", lat); end
    n_cmp++; if (div_out !== 64'h100) begin n_err++; $display("FAIL post_flush_q: got %h want 100", div_out); end
    n_cmp++; if (rem_out !== 64'd0) begin n_err++; $display("FAIL post_flush_r: got %h want 0", rem_out); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_special();
    test_word();
    test_flush();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
